// File: rtl/n2_tlb_access_ctl.sv
// TLB array access sequencer: arbitrates per-cycle CAM lookups against a single
// maintenance requester (write/read/demap) and drives registered array controls.
module n2_tlb_access_ctl #(
    parameter int RD_LAT     = 1,
    parameter int DEMAP_CYC  = 2,
    parameter int STARVE_MAX = 7
) (
    input  logic       l2clk,
    input  logic       rst,
    input  logic       cfg_bypass,
    input  logic       lkup_vld,
    output logic       lkup_stall,
    input  logic       mnt_req,
    input  logic [1:0] mnt_op,
    input  logic [5:0] mnt_idx,
    input  logic       mnt_idx_vld,
    input  logic [1:0] mnt_dmap_type,
    input  logic       mnt_dmap_real,
    output logic       mnt_ack,
    output logic       mnt_rd_done,
    output logic       tlb_cam_vld,
    output logic       tlb_wr_vld,
    output logic       tlb_rd_vld,
    output logic [5:0] tlb_rw_index,
    output logic       tlb_rw_index_vld,
    output logic       tlb_demap,
    output logic       tlb_demap_context,
    output logic       tlb_demap_all,
    output logic       tlb_demap_real,
    output logic       tlb_bypass
);

    localparam int BUSY_MAX = (RD_LAT > DEMAP_CYC) ? RD_LAT : DEMAP_CYC;
    localparam int BUSY_W   = $clog2(BUSY_MAX + 1);
    localparam int RD_W     = $clog2(RD_LAT + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_DMAP = 2'b10;

    // Returns {context, all}; type 11 falls through to a page demap.
    function automatic logic [1:0] dmap_decode(input logic [1:0] dmap_type);
        logic [1:0] q;
        q = 2'b00;
        case (dmap_type)
            2'b01:   q = 2'b10;
            2'b10:   q = 2'b01;
            default: q = 2'b00;
        endcase
        return q;
    endfunction

    logic [BUSY_W-1:0]   busy_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic [RD_W-1:0]     rd_cnt;

    logic idle;
    logic starved;
    logic grant;
    logic grant_wr;
    logic grant_rd;
    logic grant_dmap;
    logic [1:0] dmap_qual;

    logic       cam_vld_p1;
    logic       wr_vld_p1;
    logic       rd_vld_p1;
    logic       rd_done_p1;
    logic       bypass_p1;
    logic [5:0] rw_index_p1;
    logic       rw_index_vld_p1;
    logic       dmap_op_p1;
    logic       dmap_ctx_p1;
    logic       dmap_all_p1;
    logic       dmap_real_p1;

    // Arbitration: lookups win unless maintenance has lost STARVE_MAX times.
    always_comb begin
        idle       = (busy_cnt == '0);
        starved    = (starve_cnt == STARVE_W'(STARVE_MAX));
        grant      = ~rst & idle & mnt_req & (~lkup_vld | starved);
        grant_wr   = grant & (mnt_op == OP_WR);
        grant_rd   = grant & (mnt_op == OP_RD);
        grant_dmap = grant & (mnt_op == OP_DMAP);
        dmap_qual  = dmap_decode(mnt_dmap_type);
    end

    assign mnt_ack    = grant;
    assign lkup_stall = grant | ~idle;

    // Occupancy and fairness counters.
    always_ff @(posedge l2clk) begin
        if (rst) begin
            busy_cnt   <= '0;
            starve_cnt <= '0;
            rd_cnt     <= '0;
        end else begin
            if (grant_rd)
                busy_cnt <= BUSY_W'(RD_LAT);
            else if (grant_dmap)
                busy_cnt <= BUSY_W'(DEMAP_CYC);
            else if (!idle)
                busy_cnt <= busy_cnt - BUSY_W'(1);

            if (grant || !mnt_req)
                starve_cnt <= '0;
            else if (idle && lkup_vld && !starved)
                starve_cnt <= starve_cnt + STARVE_W'(1);

            if (grant_rd)
                rd_cnt <= RD_W'(RD_LAT);
            else if (rd_cnt != '0)
                rd_cnt <= rd_cnt - RD_W'(1);
        end
    end

    // Stage p1: registered array strobes, index and demap qualifiers.
    always_ff @(posedge l2clk) begin
        if (rst) begin
            cam_vld_p1      <= 1'b0;
            wr_vld_p1       <= 1'b0;
            rd_vld_p1       <= 1'b0;
            rd_done_p1      <= 1'b0;
            bypass_p1       <= 1'b0;
            rw_index_p1     <= '0;
            rw_index_vld_p1 <= 1'b0;
            dmap_op_p1      <= 1'b0;
            dmap_ctx_p1     <= 1'b0;
            dmap_all_p1     <= 1'b0;
            dmap_real_p1    <= 1'b0;
        end else begin
            cam_vld_p1 <= lkup_vld & ~lkup_stall;
            wr_vld_p1  <= grant_wr;
            rd_vld_p1  <= grant_rd;
            rd_done_p1 <= (rd_cnt == RD_W'(1));
            bypass_p1  <= cfg_bypass;

            if (grant_wr || grant_rd) begin
                rw_index_p1     <= mnt_idx;
                rw_index_vld_p1 <= mnt_idx_vld;
            end

            // Any grant retires the previous op so a stale demap never reappears.
            if (grant)
                dmap_op_p1 <= grant_dmap;
            if (grant_dmap) begin
                dmap_ctx_p1  <= dmap_qual[1];
                dmap_all_p1  <= dmap_qual[0];
                dmap_real_p1 <= mnt_dmap_real;
            end
        end
    end

    assign tlb_cam_vld       = cam_vld_p1;
    assign tlb_wr_vld        = wr_vld_p1;
    assign tlb_rd_vld        = rd_vld_p1;
    assign mnt_rd_done       = rd_done_p1;
    assign tlb_bypass        = bypass_p1;
    assign tlb_rw_index      = rw_index_p1;
    assign tlb_rw_index_vld  = rw_index_vld_p1;
    assign tlb_demap         = dmap_op_p1 & ~idle;
    assign tlb_demap_context = tlb_demap & dmap_ctx_p1;
    assign tlb_demap_all     = tlb_demap & dmap_all_p1;
    assign tlb_demap_real    = tlb_demap & dmap_real_p1;

endmodule
